// File: rtl/encoder_arbiter_if.sv
// Bundle of requester, encoder and response signals around encoder_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system
// (requesters, the shared encoder and the response consumer).
interface encoder_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  // Requester byte streams
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  // Shared encoder input and output
  logic [7:0]           enc_in_data;
  logic                 enc_in_valid;
  logic [11:0]          enc_out_data;
  logic                 enc_out_valid;

  // Tagged responses and status
  logic [11:0]          rsp_data;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_last;
  logic                 busy;
  logic                 err;

  modport slave (
    input  req_valid, req_data, req_last, enc_out_data, enc_out_valid,
    output req_ready, enc_in_data, enc_in_valid,
           rsp_data, rsp_valid, rsp_id, rsp_last, busy, err
  );

  modport master (
    output req_valid, req_data, req_last, enc_out_data, enc_out_valid,
    input  req_ready, enc_in_data, enc_in_valid,
           rsp_data, rsp_valid, rsp_id, rsp_last, busy, err
  );
endinterface

// File: rtl/encoder_arbiter.sv
// encoder_arbiter: shares one byte-in / 12-bit-Hamming-out packet encoder
// among NUM_REQ requesters. One requester is granted at a time, its bytes
// are passed straight through to the encoder, and the encoder's burst is
// routed back tagged with the owner's id.
//
// Compile-time option: define ENC_ARB_FIXED_PRIO_EN to replace round-robin
// arbitration with fixed priority (lowest index wins). Default is
// round-robin starting after the last granted requester.
module encoder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MAX_LEN = 255
) (
  input  logic               clk,
  input  logic               rst,
  encoder_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [7:0]      MAX_CNT = 8'(MAX_LEN);
  localparam logic [ID_W-1:0] TOP_ID  = ID_W'(NUM_REQ - 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] grant, grant_nxt;
  logic [ID_W-1:0] last_grant, last_grant_nxt;
  logic [7:0]      sent_cnt, sent_nxt;
  logic [7:0]      rcv_cnt, rcv_nxt;
  logic [ID_W-1:0] winner;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  logic               g_vld;
  logic               g_last;
  logic [7:0]         g_data;

  logic [NUM_REQ-1:0] req_ready_c;
  logic               enc_in_valid_c;
  logic [7:0]         enc_in_data_c;
  logic               rsp_valid_c;
  logic [11:0]        rsp_data_c;
  logic [ID_W-1:0]    rsp_id_c;
  logic               rsp_last_c;
  logic               err_c;

  assign req_valid = bus.req_valid;
  assign req_last  = bus.req_last;

  // Signals of the currently granted requester.
  assign g_vld  = req_valid[grant];
  assign g_last = req_last[grant];
  assign g_data = bus.req_data[{grant, 3'b000} +: 8];

`ifdef ENC_ARB_FIXED_PRIO_EN
  // Lowest-index valid requester wins; scanning downward lets the lowest
  // index overwrite any higher one.
  function automatic logic [ID_W-1:0] fp_pick(input logic [NUM_REQ-1:0] vld);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;
    pick = '0;
    cand = TOP_ID;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (vld[cand]) pick = cand;
      cand = cand - 1'b1;
    end
    return pick;
  endfunction

  assign winner = fp_pick(req_valid);
`else
  // Round-robin: search starts one past the previous winner, wrapping at
  // NUM_REQ, so the previous winner has lowest priority.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;
    logic            found;
    pick  = '0;
    found = 1'b0;
    cand  = last;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand == TOP_ID) cand = '0;
      else                cand = cand + 1'b1;
      if (!found && vld[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(req_valid, last_grant);
`endif

  // State, grant and byte/word counters; reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= TOP_ID;
      sent_cnt   <= '0;
      rcv_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      sent_cnt   <= sent_nxt;
      rcv_cnt    <= rcv_nxt;
    end
  end

  // Next-state and all outputs; everything is held at zero while rst is high.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    sent_nxt       = sent_cnt;
    rcv_nxt        = rcv_cnt;
    req_ready_c    = '0;
    enc_in_valid_c = 1'b0;
    enc_in_data_c  = '0;
    rsp_valid_c    = 1'b0;
    rsp_data_c     = '0;
    rsp_id_c       = '0;
    rsp_last_c     = 1'b0;
    err_c          = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_nxt      = winner;
            last_grant_nxt = winner;
            state_nxt      = SEND;
          end
        end
        SEND: begin
          enc_in_valid_c = g_vld;
          enc_in_data_c  = g_data;
          if (g_vld) begin
            req_ready_c[grant] = 1'b1;
            sent_nxt           = sent_cnt + 8'd1;
            // Closing at MAX_LEN keeps the encoder's 8-bit length in range;
            // the requester's remaining bytes become a fresh packet.
            if (g_last || (sent_cnt + 8'd1 == MAX_CNT)) state_nxt = WAIT;
          end else if (sent_cnt != 8'd0) begin
            // A bubble mid-packet closes the encoder packet as it stands.
            err_c     = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
        WAIT: begin
          if (bus.enc_out_valid) begin
            rsp_valid_c = 1'b1;
            rsp_data_c  = bus.enc_out_data;
            rsp_id_c    = grant;
            rcv_nxt     = rcv_cnt + 8'd1;
            if (rcv_cnt + 8'd1 == sent_cnt) begin
              rsp_last_c = 1'b1;
              state_nxt  = GAP;
            end
          end
        end
        GAP: begin
          // One dead cycle lets the encoder fall back to its initial state.
          sent_nxt  = '0;
          rcv_nxt   = '0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.enc_in_valid = enc_in_valid_c;
  assign bus.enc_in_data  = enc_in_data_c;
  assign bus.rsp_valid    = rsp_valid_c;
  assign bus.rsp_data     = rsp_data_c;
  assign bus.rsp_id       = rsp_id_c;
  assign bus.rsp_last     = rsp_last_c;
  assign bus.err          = err_c;
  assign bus.busy         = (state != IDLE) && !rst;

endmodule

// File: tb/tb_encoder_arbiter.sv
// Self-checking bench for encoder_arbiter. Requesters are byte queues, the
// shared encoder is a small behavioural model (collect bytes until input
// valid drops, wait two cycles, emit one Hamming word per byte), and every
// response word is logged and compared against an expected word list built
// from the bytes the bench queued.
module tb_encoder_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int MAX_LEN = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  encoder_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  encoder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_LEN(MAX_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int base;
    int len;
    int exp_len0;
    int exp_len1;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int viol = 0;

  logic [8:0]  src_q [NUM_REQ][$];
  int          bubble_at [NUM_REQ];
  int          acc_cnt [NUM_REQ];
  int          gap_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]   acc_neg = '0;
  logic [NUM_REQ-1:0]   drv_vld;
  logic [8*NUM_REQ-1:0] drv_dat;
  logic [NUM_REQ-1:0]   drv_lst;

  logic [14:0] rsp_log[$];
  logic [14:0] exp_log[$];

  logic [7:0] enc_q[$];
  logic [7:0] out_q[$];
  bit         in_pkt = 1'b0;
  int         dly = 0;
  logic       enc_v_s = 1'b0;
  logic [7:0] enc_d_s = '0;
  logic       rst_s = 1'b1;

  function automatic logic [11:0] ham(input logic [7:0] d);
    logic [11:0] w;
    w = '0;
    w[2] = d[0]; w[4] = d[1]; w[5] = d[2]; w[6] = d[3];
    w[8] = d[4]; w[9] = d[5]; w[10] = d[6]; w[11] = d[7];
    w[0] = w[2] ^ w[4] ^ w[6] ^ w[8] ^ w[10];
    w[1] = w[2] ^ w[5] ^ w[6] ^ w[9] ^ w[10];
    w[3] = w[4] ^ w[5] ^ w[6] ^ w[11];
    w[7] = w[8] ^ w[9] ^ w[10] ^ w[11];
    return w;
  endfunction

  function automatic bit src_empty();
    for (int i = 0; i < NUM_REQ; i++)
      if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_pkt(input int id, input int base, input int len);
    for (int k = 0; k < len; k++)
      src_q[id].push_back({(k == len - 1), 8'(base + k)});
  endtask

  task automatic exp_pkt(input int id, input int base, input int len);
    for (int k = 0; k < len; k++)
      exp_log.push_back({2'(id), (k == len - 1), ham(8'(base + k))});
  endtask

  task automatic run_idle(input string tag);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (src_empty() && !bus.busy && out_q.size() == 0 && !in_pkt &&
          dly == 0 && !bus.enc_out_valid) quiet++;
      else quiet = 0;
    end
    chk({tag, ".done"}, (quiet >= 3), 1);
  endtask

  task automatic compare_log(input string tag);
    chk({tag, ".words"}, rsp_log.size(), exp_log.size());
    for (int k = 0; k < exp_log.size() && k < rsp_log.size(); k++)
      chk($sformatf("%s.w%0d", tag, k), rsp_log[k], exp_log[k]);
    rsp_log.delete();
    exp_log.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Monitor: samples everything mid-cycle.
  always @(negedge clk) begin
    acc_neg = bus.req_valid & bus.req_ready;
    enc_v_s = bus.enc_in_valid;
    enc_d_s = bus.enc_in_data;
    rst_s   = rst;
    if (bus.rsp_valid) rsp_log.push_back({bus.rsp_id, bus.rsp_last, bus.rsp_data});
    if (bus.err) err_cnt++;
    if (((bus.req_ready & ~bus.req_valid) != '0) || !$onehot0(bus.req_ready)) viol++;
  end

  // Requester driver: retire accepted bytes, optionally insert a one-cycle bubble.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_neg[i] && src_q[i].size() > 0) begin
        src_q[i].delete(0);
        acc_cnt[i]++;
        if (acc_cnt[i] == bubble_at[i]) begin
          gap_cnt[i]   = 1;
          bubble_at[i] = -1;
        end
      end
      if (gap_cnt[i] > 0) begin
        drv_vld[i] = 1'b0;
        drv_lst[i] = 1'b0;
        gap_cnt[i]--;
      end else if (src_q[i].size() > 0) begin
        drv_vld[i]         = 1'b1;
        drv_dat[i*8 +: 8]  = src_q[i][0][7:0];
        drv_lst[i]         = src_q[i][0][8];
      end else begin
        drv_vld[i] = 1'b0;
        drv_lst[i] = 1'b0;
      end
    end
    bus.req_valid = drv_vld;
    bus.req_data  = drv_dat;
    bus.req_last  = drv_lst;
  end

  // Encoder model: shares rst, closes a packet when input valid drops.
  always @(posedge clk) begin
    #1;
    if (rst_s) begin
      enc_q.delete();
      out_q.delete();
      in_pkt = 1'b0;
      dly    = 0;
      bus.enc_out_valid = 1'b0;
      bus.enc_out_data  = '0;
    end else begin
      bus.enc_out_valid = 1'b0;
      if (enc_v_s) begin
        enc_q.push_back(enc_d_s);
        in_pkt = 1'b1;
      end else if (in_pkt) begin
        in_pkt = 1'b0;
        foreach (enc_q[k]) out_q.push_back(enc_q[k]);
        enc_q.delete();
        dly = 2;
      end
      if (dly > 0) dly--;
      else if (out_q.size() > 0) begin
        bus.enc_out_valid = 1'b1;
        bus.enc_out_data  = ham(out_q[0]);
        out_q.delete(0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int n;

    vecs[0] = '{0, 8'h00, 1, 1, 0};
    vecs[1] = '{1, 8'hA5, 3, 3, 0};
    vecs[2] = '{3, 8'h10, 255, 255, 0};
    vecs[3] = '{2, 8'h40, 256, 255, 1};
    vecs[4] = '{2, 8'h00, 300, 255, 45};

    for (int i = 0; i < NUM_REQ; i++) begin
      bubble_at[i] = -1;
      acc_cnt[i]   = 0;
      gap_cnt[i]   = 0;
    end
    drv_vld = '0; drv_dat = '0; drv_lst = '0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    bus.enc_out_valid = 1'b0; bus.enc_out_data = '0;

    // Reset with a request already pending: nothing may leak out.
    push_pkt(0, 8'h00, 1);
    repeat (3) @(negedge clk);
    chk("rst.busy", bus.busy, 0);
    chk("rst.req_ready", bus.req_ready, 0);
    chk("rst.enc_in_valid", bus.enc_in_valid, 0);
    chk("rst.rsp_valid", bus.rsp_valid, 0);
    chk("rst.err", bus.err, 0);

    // Single byte: grant latency 1, one encoder byte, one response word.
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("lat.idle_busy", bus.busy, 0);
    chk("lat.idle_enc_v", bus.enc_in_valid, 0);
    chk("lat.idle_ready", bus.req_ready, 0);
    @(negedge clk);
    chk("lat.send_busy", bus.busy, 1);
    chk("lat.send_enc_v", bus.enc_in_valid, 1);
    chk("lat.send_enc_d", bus.enc_in_data, 8'h00);
    chk("lat.send_ready", bus.req_ready, 4'b0001);
    @(negedge clk);
    chk("lat.wait_enc_v", bus.enc_in_valid, 0);
    chk("lat.wait_ready", bus.req_ready, 0);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lat.rsp_valid", bus.rsp_valid, 1);
    chk("lat.rsp_data", bus.rsp_data, 12'h000);
    chk("lat.rsp_id", bus.rsp_id, 0);
    chk("lat.rsp_last", bus.rsp_last, 1);
    @(negedge clk);
    chk("lat.gap_busy", bus.busy, 1);
    chk("lat.gap_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    chk("lat.after_busy", bus.busy, 0);
    rsp_log.delete();
    run_idle("lat");

    // Table: single-requester packets, including MAX_LEN splits.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      err_cnt = 0;
      push_pkt(vecs[v].id, vecs[v].base, vecs[v].len);
      exp_pkt(vecs[v].id, vecs[v].base, vecs[v].exp_len0);
      if (vecs[v].exp_len1 > 0)
        exp_pkt(vecs[v].id, vecs[v].base + vecs[v].exp_len0, vecs[v].exp_len1);
      run_idle($sformatf("vec%0d", v));
      compare_log($sformatf("vec%0d", v));
      chk($sformatf("vec%0d.err", v), err_cnt, 0);
    end

    // Requesters 1 and 3, two 2-byte packets each.
    do_reset();
    @(negedge clk);
    push_pkt(1, 8'h11, 2); push_pkt(1, 8'h13, 2);
    push_pkt(3, 8'h31, 2); push_pkt(3, 8'h33, 2);
`ifdef ENC_ARB_FIXED_PRIO_EN
    exp_pkt(1, 8'h11, 2); exp_pkt(1, 8'h13, 2);
    exp_pkt(3, 8'h31, 2); exp_pkt(3, 8'h33, 2);
`else
    exp_pkt(1, 8'h11, 2); exp_pkt(3, 8'h31, 2);
    exp_pkt(1, 8'h13, 2); exp_pkt(3, 8'h33, 2);
`endif
    run_idle("rr13");
    compare_log("rr13");

    // Requesters 0 and 2 both keep requesting.
    do_reset();
    @(negedge clk);
    push_pkt(0, 8'h01, 1); push_pkt(0, 8'h02, 1);
    push_pkt(2, 8'h21, 1); push_pkt(2, 8'h22, 1);
`ifdef ENC_ARB_FIXED_PRIO_EN
    exp_pkt(0, 8'h01, 1); exp_pkt(0, 8'h02, 1);
    exp_pkt(2, 8'h21, 1); exp_pkt(2, 8'h22, 1);
`else
    exp_pkt(0, 8'h01, 1); exp_pkt(2, 8'h21, 1);
    exp_pkt(0, 8'h02, 1); exp_pkt(2, 8'h22, 1);
`endif
    run_idle("prio02");
    compare_log("prio02");

    // Bubble after 3 bytes: err once, 3 words, then the rest as a new packet.
    @(negedge clk);
    err_cnt = 0;
    bubble_at[0] = acc_cnt[0] + 3;
    push_pkt(0, 8'h50, 5);
    exp_pkt(0, 8'h50, 3);
    exp_pkt(0, 8'h53, 2);
    run_idle("bubble");
    compare_log("bubble");
    chk("bubble.err", err_cnt, 1);

    // Reset during the output burst aborts cleanly.
    @(negedge clk);
    push_pkt(1, 8'h60, 4);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rstw.burst_seen", bus.rsp_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rstw.in_rst_busy", bus.busy, 0);
    chk("rstw.in_rst_rsp", bus.rsp_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw.busy", bus.busy, 0);
    chk("rstw.rsp_valid", bus.rsp_valid, 0);
    chk("rstw.req_ready", bus.req_ready, 0);
    rsp_log.delete();
    exp_log.delete();
    push_pkt(2, 8'h77, 1);
    exp_pkt(2, 8'h77, 1);
    run_idle("rstw.after");
    compare_log("rstw.after");

    chk("ready_onehot", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/encoder_arbiter.md
Name: encoder_arbiter

Overview:
- Shares one packet encoder (byte-stream in, 12-bit Hamming words out) among NUM_REQ requesters.
- Grants one requester at a time and streams its packet into the encoder's in_data/in_valid. It then waits for the encoder's full output burst and routes every 12-bit word back, tagged with the requester id.
- Sits between the requester byte streams and the single encoder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must equal ceil(log2(NUM_REQ)).
- MAX_LEN, 255, maximum bytes per encoder packet; matches the encoder's 8-bit length counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  marks final byte of the packet
- req_ready  out  NUM_REQ  byte accepted this cycle (only the granted bit may be 1)
- enc_in_data  out  8  byte to encoder
- enc_in_valid  out  1  encoder input valid
- enc_out_data  in  12  encoder output word
- enc_out_valid  in  1  encoder output valid
- rsp_data  out  12  encoded word returned to requester
- rsp_valid  out  1  rsp_data valid
- rsp_id  out  ID_W  owner of rsp_data
- rsp_last  out  1  final word of the packet
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on protocol bubble

Behaviour:
- Reset: state=IDLE, grant=0, last_grant=NUM_REQ-1, sent_cnt=0, rcv_cnt=0.
  - All outputs are 0 during reset and in IDLE.
  - A reset mid-packet aborts immediately. The encoder shares rst, so both restart clean.
- States and transitions:
  - IDLE: if any req_valid, choose a winner, register grant and last_grant, go to SEND next cycle. Grant latency is 1 cycle. Otherwise stay.
  - Arbitration is round-robin: search starts at last_grant+1, modulo NUM_REQ. After reset, requester 0 has top priority.
  - SEND: combinational pass-through.
    - enc_in_valid = req_valid[grant]; enc_in_data = req_data[grant]; req_ready[grant] = req_valid[grant].
    - Each accepted byte increments sent_cnt.
  - SEND exits to WAIT (enc_in_valid deasserts the next cycle, which closes the encoder packet) on any of:
    - Accepted byte with req_last=1.
    - Accepted byte that makes sent_cnt == MAX_LEN. req_ready drops; the remaining bytes compete as a new packet.
    - req_valid[grant]=0 with sent_cnt>0: this is a bubble. err pulses for 1 cycle and the packet is ended as sent.
  - SEND with req_valid[grant]=0 and sent_cnt==0 returns to IDLE with no error and no response.
  - WAIT: enc_in_valid=0 and all req_ready=0.
    - Each enc_out_valid drives rsp_valid=1, rsp_data=enc_out_data, rsp_id=grant, and increments rcv_cnt. All combinational, same cycle.
    - rsp_last=1 when rcv_cnt+1 == sent_cnt.
    - On that word, go to GAP.
  - GAP: 1 idle cycle so the encoder returns to its INIT state. Clear sent_cnt and rcv_cnt, go to IDLE.
  - Consequence: a new packet's first byte never reaches the encoder earlier than 3 cycles after the previous rsp_last.
- Counters are 8 bits and never wrap, because sent_cnt ≤ MAX_LEN.
- enc_out_valid seen outside WAIT is ignored; no rsp is produced.
- req_last is ignored when req_valid is low.

Optional Feature:
- Macro: ENC_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins and last_grant is unused.
- Undefined (default): round-robin as above.

Test Plan:
- Single-byte packet: req 0 sends 0x00 with last=1 → grant next cycle; enc_in_valid high for 1 cycle. After the encoder burst, 1 rsp with rsp_data=0x000, rsp_id=0, rsp_last=1; busy falls after GAP.
- Round-robin: req 1 and req 3 both hold valid 2-byte packets → req 1 served first, then req 3. A repeat from both → req 3 no longer wins ahead of req 1 out of turn; order is 1,3,1,3. rsp_id matches per burst and each burst has 2 rsp words.
- MAX_LEN split: req 2 streams 300 bytes, last on byte 300 → first packet 255 bytes with 255 rsp words and rsp_last on word 255. Then a second grant of 45 bytes with 45 rsp words.
- Bubble: req 0 sends 3 bytes, drops valid 1 cycle, then resumes → err pulses once. 3 rsp words are returned; the resumed bytes form a new packet after GAP.
- Reset mid-WAIT: rst asserted during the output burst → next cycle busy=0, rsp_valid=0, req_ready=0. A following 1-byte request is served normally.
- With ENC_ARB_FIXED_PRIO_EN: req 0 and req 2 continuously valid → req 0 granted every time, req 2 never.
